// File: rtl/spi_cmd_serializer.sv
// SPI mode-0 master that shifts one command frame {valid_bit, opcode, key, text, dest}
// MSB-first inside a single cs_n-low window, then holds cs_n high for a fixed gap.
module spi_cmd_serializer #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               valid_bit,
  input  logic [OPCODEW-1:0] opcode,
  input  logic [ADDRW-1:0]   key_addr,
  input  logic [ADDRW-1:0]   text_addr,
  input  logic [ADDRW-1:0]   dest_addr,
  output logic               spi_clk,
  output logic               mosi,
  output logic               cs_n,
  output logic               done
);

  localparam int FW     = 1 + OPCODEW + 3 * ADDRW;
  localparam int BCW    = $clog2(FW + 1);
  localparam int CNT_MX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW     = (CNT_MX > 1) ? $clog2(CNT_MX) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt_div;
  logic [BCW-1:0]  bit_cnt;
  logic [FW-1:0]   shift;
  logic [FW-1:0]   frame_in;
  logic            phase_end;
  logic            gap_end;

  assign frame_in  = {valid_bit, opcode, key_addr, text_addr, dest_addr};
  assign phase_end = (cnt_div == CW'(CLK_DIV - 1));
  assign gap_end   = (cnt_div == CW'(CS_GAP - 1));

  // NOTE: every register here, including the shift register, uses non-blocking
  // assignments and is reset so a mid-frame reset leaves no stale frame data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_div   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      cs_n      <= 1'b1;
      spi_clk   <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
      ready_out <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            shift     <= frame_in;
            mosi      <= frame_in[FW-1];
            cs_n      <= 1'b0;
            spi_clk   <= 1'b0;
            ready_out <= 1'b0;
            cnt_div   <= '0;
            bit_cnt   <= '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          if (phase_end) begin
            cnt_div <= '0;
            spi_clk <= 1'b1;
            state   <= HIGH;
          end else begin
            cnt_div <= cnt_div + 1'b1;
          end
        end

        HIGH: begin
          if (phase_end) begin
            cnt_div <= '0;
            spi_clk <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BCW'(FW - 1)) begin
              state <= HOLD;
            end else begin
              // Data changes only on the falling edge so the receiver samples a stable bit.
              shift <= shift << 1;
              mosi  <= shift[FW-2];
              state <= LOW;
            end
          end else begin
            cnt_div <= cnt_div + 1'b1;
          end
        end

        LOW: begin
          if (phase_end) begin
            cnt_div <= '0;
            spi_clk <= 1'b1;
            state   <= HIGH;
          end else begin
            cnt_div <= cnt_div + 1'b1;
          end
        end

        HOLD: begin
          if (phase_end) begin
            cnt_div <= '0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            state   <= GAP;
          end else begin
            cnt_div <= cnt_div + 1'b1;
          end
        end

        GAP: begin
          if (gap_end) begin
            cnt_div   <= '0;
            ready_out <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt_div <= cnt_div + 1'b1;
          end
        end

        default: begin
          cnt_div   <= '0;
          cs_n      <= 1'b1;
          spi_clk   <= 1'b0;
          mosi      <= 1'b0;
          ready_out <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
